serial_subtractor: RTL and testbench

- Bit-serial 17-bit unsigned subtractor; computes in0 - in1 one bit per clock, LSB first.
- Produces an 18-bit two's-complement result.
- Built from a single 1-bit full-subtractor cell with a registered borrow. It is the inverse-direction counterpart of the team's ripple full-adder datapath.
- Sits beside that adder wherever a difference is needed and area matters more than latency. Uses a start/busy/done handshake.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM encoding
// and the bit-counter sizing helper.
package serial_subtractor_pkg;

    localparam int WIDTH_DEF = 17;
    localparam int RES_W     = WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One spare bit so the counter can never wrap inside an operation.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
    output logic bout,
    output logic diff,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock through a single
// full-subtractor cell; result is {final borrow, difference}.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH:0]   out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; operands loaded on acceptance
    // RUN   | one bit processed per edge, LSB first
    // DONE  | result published, done pulse high for this cycle

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-2:0]    r_diff;
    logic                r_borrow;
    logic [CW-1:0]       r_count;
    logic [WIDTH:0]      r_out;
    logic                r_zero;
    logic                r_busy;
    logic                r_done;
    logic                w_d;
    logic                w_bout;
    logic [WIDTH-1:0]    w_diff_final;

    full_subtractor u_fs (
        .bout (w_bout),
        .diff (w_d),
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow)
    );

    // On the last edge the newest bit lands on top of the bits already collected.
    assign w_diff_final = {w_d, r_diff};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next = (r_count == LAST) ? ST_DONE : ST_RUN;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_out    <= '0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= in0;
                        r_b      <= in1;
                        r_borrow <= 1'b0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_diff   <= {w_d, r_diff[WIDTH-2:1]};
                    r_borrow <= w_bout;
                    r_count  <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_out  <= {w_bout, w_diff_final};
                        r_zero <= ~w_bout && (w_diff_final == '0);
                        r_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign zero = r_zero;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench for serial_subtractor against an arithmetic
// reference (in0 - in1 taken modulo 2^18).
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [16:0] in0 = '0;
    logic [16:0] in1 = '0;
    logic [17:0] out;
    logic        zero;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(17)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in0    (in0),
        .in1    (in1),
        .out    (out),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] model(input int a, input int b);
        int d;
        d = a - b;
        return 18'(d);
    endfunction

    // Launches one operation and watches 24 cycles after the accepting edge.
    task automatic do_op(input logic [16:0] a, input logic [16:0] b, input bit noise,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output bit early);
        logic [17:0] prev_out;
        logic        prev_zero;
        @(posedge clk); #1;
        in0 = a; in1 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prev_out = out; prev_zero = zero;
        lat = -1; busy_cnt = 0; done_cnt = 0; early = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) lat = i;
            end
            if (lat < 0 && (out !== prev_out || zero !== prev_zero)) early = 1'b1;
            if (noise && i < 15) begin
                start = (i % 2 == 0);
                in0 = (i % 3 == 0) ? 17'd100 : 17'($urandom);
                in1 = (i % 3 == 0) ? 17'd1 : 17'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int lat, bc, dc;
        bit early;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        in0 = 17'($urandom); in1 = 17'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out, zero, busy, done} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h zero=%b busy=%b done=%b, required all 0", out, zero, busy, done);
        end
        resetn = 1'b1;
        do_op(17'd5, 17'd3, 1'b0, lat, bc, dc, early);
        checks++;
        if (out !== 18'h00002 || lat != 17) begin
            errors++;
            $display("FAIL reset_then_5m3: out=%h lat=%0d, required 00002 lat=17", out, lat);
        end
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        bit early;
        do_op(17'd5000, 17'd1234, 1'b0, lat, bc, dc, early);
        checks++;
        if (bc != 18) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d cycles, required 18", bc);
        end
        checks++;
        if (dc != 1 || lat != 17) begin
            errors++;
            $display("FAIL basic_done: count=%0d at=%0d, required count=1 at=17", dc, lat);
        end
        checks++;
        if (out !== model(5000, 1234) || out !== 18'h00EB6 || zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: out=%h zero=%b, required 00eb6 zero=0", out, zero);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_edges();
        int lat, bc, dc;
        bit early;
        logic [16:0] ta [3] = '{17'd0, 17'h1FFFF, 17'd0};
        logic [16:0] tb [3] = '{17'd1, 17'd0, 17'h1FFFF};
        logic [17:0] te [3] = '{18'h3FFFF, 18'h1FFFF, 18'h20001};
        for (int k = 0; k < 3; k++) begin
            do_op(ta[k], tb[k], 1'b0, lat, bc, dc, early);
            checks++;
            if (out !== te[k] || out !== model(int'(ta[k]), int'(tb[k])) || zero !== 1'b0) begin
                errors++;
                $display("FAIL edge_%0d: out=%h zero=%b, required %h zero=0", k, out, zero, te[k]);
            end
        end
    endtask

    task automatic test_equal();
        int lat, bc, dc;
        bit early;
        do_op(17'h1FFFF, 17'h1FFFF, 1'b0, lat, bc, dc, early);
        checks++;
        if (out !== 18'h00000 || zero !== 1'b1) begin
            errors++;
            $display("FAIL equal_zero: out=%h zero=%b, required 00000 zero=1", out, zero);
        end
        do_op(17'd3, 17'd2, 1'b0, lat, bc, dc, early);
        checks++;
        if (early !== 1'b0 || lat != 17) begin
            errors++;
            $display("FAIL equal_hold: early_change=%b lat=%0d, required 0 and 17", early, lat);
        end
        checks++;
        if (out !== 18'h00001 || zero !== 1'b0) begin
            errors++;
            $display("FAIL equal_next: out=%h zero=%b, required 00001 zero=0", out, zero);
        end
    endtask

    task automatic test_ignored();
        int lat, bc, dc;
        bit early;
        do_op(17'd7, 17'd2, 1'b1, lat, bc, dc, early);
        checks++;
        if (dc != 1 || lat != 17) begin
            errors++;
            $display("FAIL ignored_done: count=%0d at=%0d, required 1 at 17", dc, lat);
        end
        checks++;
        if (out !== 18'h00005 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_result: out=%h busy=%b, required 00005 busy=0", out, busy);
        end
    endtask

    task automatic test_abort_continuous();
        int dones[$];
        int ndone = 0;
        @(posedge clk); #1;
        in0 = 17'd9; in1 = 17'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        if (done) ndone++;
        checks++;
        if ({out, zero, busy, done} !== 21'd0 || ndone != 0) begin
            errors++;
            $display("FAIL abort: out=%h zero=%b busy=%b done=%b dones=%0d, required all 0", out, zero, busy, done, ndone);
        end
        resetn = 1'b1;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                dones.push_back(n);
                checks++;
                if (out !== 18'h00005) begin
                    errors++;
                    $display("FAIL cont_result: out=%h at cycle %0d, required 00005", out, n);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones.size() != 3) begin
            errors++;
            $display("FAIL cont_count: got %0d dones, required 3", dones.size());
        end else begin
            checks++;
            if (dones[0] != 18 || dones[1] - dones[0] != 19 || dones[2] - dones[1] != 19) begin
                errors++;
                $display("FAIL cont_period: dones at %0d %0d %0d, required 18 37 56", dones[0], dones[1], dones[2]);
            end
        end
        repeat (25) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat, bc, dc;
        bit early;
        logic [16:0] a, b;
        logic [17:0] exp_v;
        for (int k = 0; k < 20; k++) begin
            a = 17'($urandom);
            b = (k % 5 == 0) ? a : 17'($urandom);
            exp_v = model(int'(a), int'(b));
            do_op(a, b, 1'b0, lat, bc, dc, early);
            checks++;
            if (out !== exp_v || zero !== (exp_v == 18'd0) || lat != 17) begin
                errors++;
                $display("FAIL random_%0d: %h-%h out=%h zero=%b lat=%0d, required %h zero=%b lat=17",
                         k, a, b, out, zero, lat, exp_v, (exp_v == 18'd0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_equal();
        test_ignored();
        test_abort_continuous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
